skid_rr_arbiter: RTL and testbench
==================================

Name: skid_rr_arbiter

Overview:
- Shares one valid/ready output stream, normally the input side of a skid_buffer, among N_PORTS requesters.
- Round-robin arbitration at packet granularity: a grant stays on one port until that port sends `last`, or until MAX_BURST beats have gone through.
- A single output register stage gives the downstream skid_buffer a registered valid/data.
- Every output beat carries the source port id.

Parameters:
- N_PORTS, 4, number of requesters (2..16).
- DATA_WIDTH, 32, payload width per beat.
- MAX_BURST, 16, maximum beats per grant before forced rotation; 0 means unlimited (rotate on `last` only).
- ID_W, $clog2(N_PORTS), width of the port id.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid_i  input  N_PORTS  per-port beat valid.
- in_ready_o  output  N_PORTS  per-port beat accept.
- in_data_i  input  N_PORTS x DATA_WIDTH  per-port payload.
- in_last_i  input  N_PORTS  per-port end-of-packet.
- out_valid_o  output  1  registered output valid.
- out_ready_i  input  1  downstream accept.
- out_data_o  output  DATA_WIDTH  registered payload.
- out_last_o  output  1  registered end-of-packet.
- out_id_o  output  ID_W  source port of the current output beat.

Behaviour:
- Reset (rst==0, async):
  - out_valid_o=0, out_data_o=0, out_last_o=0, out_id_o=0.
  - state=IDLE, rr_ptr=N_PORTS-1 so port 0 has first priority, beat_cnt=0, owner=0.
  - in_ready_o is forced to 0 while rst==0.
- Output stage:
  - can_load = !out_valid_o || out_ready_i (combinational path from out_ready_i).
  - When a beat is accepted, load data/last/id and set out_valid_o=1.
  - If out_ready_i is high and no beat is accepted, clear out_valid_o.
  - Payload fields hold their value while out_valid_o is high and out_ready_i is low.
- Handshake: in_ready_o[i] = can_load && (winner==i). At most one bit is set per cycle. A beat is accepted when in_valid_i[i] && in_ready_o[i].
- Latency: an accepted beat appears on out_* the next cycle. Throughput is 1 beat/cycle with out_ready_i held high.
- State machine (states IDLE, LOCKED):
  - IDLE: winner = first port with in_valid_i set, scanning from rr_ptr+1 upward with wrap. No valid input means no winner and all in_ready_o low.
  - On an accepted beat in IDLE:
    - beat_cnt=1, owner=winner.
    - If in_last_i is set, or MAX_BURST==1: stay IDLE, rr_ptr=winner.
    - Otherwise go to LOCKED.
  - LOCKED: winner=owner regardless of the other ports' valids. If the owner drops valid, stall; the lock is not released.
  - On an accepted beat in LOCKED, beat_cnt increments.
  - Exit LOCKED to IDLE, with rr_ptr=owner and beat_cnt=0, when the accepted beat has in_last_i set, or when MAX_BURST!=0 and beat_cnt+1==MAX_BURST.
- Forced rotation splits the packet:
  - out_last_o stays low on the split beat.
  - The remainder resumes at that port's next grant.
  - out_id_o lets the consumer reassemble.
- beat_cnt width is $clog2(MAX_BURST+1), or 1 when MAX_BURST==0. With MAX_BURST==0 it never saturates or wraps.
- Backpressure (out_ready_i low with out_valid_o high): no beat is accepted, state/rr_ptr/beat_cnt hold, and out_* is stable.
- Reset mid-packet discards the in-flight output beat and the lock; arbitration restarts at port 0.

Decomposition:
- Package skid_arb_pkg holds:
  - enum arb_st_t {ARB_IDLE, ARB_LOCKED};
  - function rr_next (rotate-priority helper) used by the RTL and the bench model.
- Sub-module rr_pick: combinational rotating-priority selector.
  - Parameter N_PORTS.
  - Inputs: req[N], ptr[ID_W].
  - Outputs: gnt_valid, gnt_id.
- Top level holds the FSM, beat counter and output register. Its output feeds skid_buffer.

Test Plan:
- Reset release with all 4 ports valid, single-beat packets (last=1), data=0xA0+i, out_ready=1 -> out_id sequence 0,1,2,3,0…; out_data 0xA0,0xA1,0xA2,0xA3; one beat/cycle; first out_valid 1 cycle after first accept.
- Port 1 sends a 5-beat packet while ports 0 and 2 also request single beats, MAX_BURST=16 -> arbitration order 0, then 1, then 2. Port 1's 5 beats are contiguous on out_id=1, with out_last only on beat 5.
- MAX_BURST=4, port 3 sends a 10-beat packet, port 0 requests continuously -> port 3 beats 1-4 with out_last=0, then port 0, then port 3 beats 5-8, then port 0, then port 3 beats 9-10 with out_last=1 on beat 10.
- out_ready_i low for 7 cycles mid-packet -> out_data/out_id/out_last frozen; all in_ready_o low once the output register is full; no beat lost or duplicated (scoreboard).
- Locked owner (port 2) drops valid for 3 cycles while port 0 is valid -> port 0 in_ready stays 0, no port-0 beat is emitted, and port 2 resumes.
- rst pulled low mid-packet while out_valid=1 -> out_valid_o=0 immediately (async); after release, port 0 wins first and the remainder of the interrupted packet is treated as a new grant.

Source files
------------

// File: rtl/skid_arb_pkg.sv
// Shared types and the rotating-priority helper for the skid_rr_arbiter block.
package skid_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_st_t;

    // Largest port count the helper understands; narrower users zero-pad.
    localparam int RR_MAX_PORTS = 16;

    // Returns {found, id}: the first set bit of req scanning upward from
    // ptr+1 with wrap at n_ports, so the port at ptr has lowest priority.
    function automatic logic [4:0] rr_next(
        input logic [15:0] req,
        input logic [3:0]  ptr,
        input int          n_ports
    );
        logic [4:0] res;
        int         idx;
        res = 5'd0;
        for (int k = 1; k <= RR_MAX_PORTS; k++) begin
            if (k <= n_ports) begin
                idx = int'(ptr) + k;
                if (idx >= n_ports) begin
                    idx = idx - n_ports;
                end else begin
                    idx = idx;
                end
                if (!res[4] && req[idx[3:0]]) begin
                    res = {1'b1, idx[3:0]};
                end else begin
                    res = res;
                end
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/skid_rr_arbiter_rr_pick.sv
// Combinational rotating-priority selector: picks the first requester after ptr.
module rr_pick #(
    parameter int N_PORTS = 4,
    parameter int ID_W    = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id
);
    import skid_arb_pkg::*;

    logic [15:0] req_ext_s;
    logic [3:0]  ptr_ext_s;
    logic [4:0]  pick_s;

    // Widen the request/pointer to the helper's fixed width and decode the pick.
    always_comb begin
        req_ext_s                = 16'd0;
        req_ext_s[N_PORTS-1:0]   = req;
        ptr_ext_s                = 4'd0;
        ptr_ext_s[ID_W-1:0]      = ptr;
        pick_s                   = rr_next(req_ext_s, ptr_ext_s, N_PORTS);
        gnt_valid                = pick_s[4];
        gnt_id                   = ID_W'(pick_s[3:0]);
    end

endmodule

// File: rtl/skid_rr_arbiter.sv
// Packet-granular round-robin arbiter feeding one registered valid/ready stream.
// A grant is held until the owner sends last or MAX_BURST beats have passed;
// every output beat is tagged with its source port so split packets can be
// reassembled downstream.
module skid_rr_arbiter #(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int ID_W       = $clog2(N_PORTS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_PORTS-1:0]                  in_valid_i,
    output logic [N_PORTS-1:0]                  in_ready_o,
    input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]  in_data_i,
    input  logic [N_PORTS-1:0]                  in_last_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [DATA_WIDTH-1:0]               out_data_o,
    output logic                                out_last_o,
    output logic [ID_W-1:0]                     out_id_o
);
    import skid_arb_pkg::*;

    localparam int                CNT_W     = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_BURST);
    localparam logic [ID_W-1:0]   PTR_RST   = ID_W'(N_PORTS - 1);
    localparam bit                BURST_ON  = (MAX_BURST != 0);
    localparam bit                BURST_ONE = (MAX_BURST == 1);

    arb_st_t               state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]       owner_q, owner_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [ID_W-1:0]       out_id_q, out_id_d;

    logic                  can_load_s;
    logic                  pick_valid_s;
    logic [ID_W-1:0]       pick_id_s;
    logic                  winner_valid_s;
    logic [ID_W-1:0]       winner_s;
    logic [N_PORTS-1:0]    ready_s;
    logic                  accept_s;
    logic                  acc_last_s;
    logic [CNT_W-1:0]      cnt_inc_s;
    logic                  burst_done_s;

    rr_pick #(
        .N_PORTS (N_PORTS),
        .ID_W    (ID_W)
    ) u_pick (
        .req       (in_valid_i),
        .ptr       (rr_ptr_q),
        .gnt_valid (pick_valid_s),
        .gnt_id    (pick_id_s)
    );

    // Choose the winner (locked owner or round-robin pick) and form the handshake.
    always_comb begin
        can_load_s = !out_valid_q || out_ready_i;
        if (state_q == ARB_LOCKED) begin
            winner_valid_s = 1'b1;
            winner_s       = owner_q;
        end else begin
            winner_valid_s = pick_valid_s;
            winner_s       = pick_id_s;
        end
        ready_s = '0;
        if (winner_valid_s && can_load_s) begin
            ready_s[winner_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
        accept_s     = winner_valid_s && can_load_s && in_valid_i[winner_s];
        acc_last_s   = in_last_i[winner_s];
        cnt_inc_s    = beat_cnt_q + CNT_W'(1);
        burst_done_s = BURST_ON && (cnt_inc_s == CNT_LIMIT);
    end

    // Ready is held low for the whole time reset is asserted.
    assign in_ready_o = rst ? ready_s : '0;

    // Next-state for the FSM, burst counter, pointer and output register.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_id_d    = out_id_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data_i[winner_s];
            out_last_d  = acc_last_s;
            out_id_d    = winner_s;
            case (state_q)
                ARB_IDLE: begin
                    owner_d    = winner_s;
                    beat_cnt_d = CNT_W'(1);
                    if (acc_last_s || BURST_ONE) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = winner_s;
                    end else begin
                        state_d  = ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (acc_last_s || burst_done_s) begin
                        state_d    = ARB_IDLE;
                        rr_ptr_d   = owner_q;
                        beat_cnt_d = '0;
                    end else if (BURST_ON) begin
                        beat_cnt_d = cnt_inc_s;
                    end else begin
                        // Unlimited bursts: the counter is not needed, so it never moves.
                        beat_cnt_d = beat_cnt_q;
                    end
                end
                default: begin
                    state_d    = ARB_IDLE;
                    beat_cnt_d = '0;
                end
            endcase
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= PTR_RST;
            owner_q     <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_id_o    = out_id_q;

endmodule

// File: tb/tb_skid_rr_arbiter.sv
// Scoreboard bench for skid_rr_arbiter: instance 0 uses MAX_BURST=16,
// instance 1 uses MAX_BURST=4; only the selected instance gets traffic.
module tb_skid_rr_arbiter;

    typedef struct packed {
        logic        last;
        logic [1:0]  id;
        logic [31:0] data;
    } beat_t;

    logic             clk;
    logic             rst;
    logic [3:0]       in_valid  [2];
    logic [3:0]       in_ready  [2];
    logic [3:0][31:0] in_data   [2];
    logic [3:0]       in_last   [2];
    logic             out_valid [2];
    logic             out_ready [2];
    logic [31:0]      out_data  [2];
    logic             out_last  [2];
    logic [1:0]       out_id    [2];

    int          cur;
    logic        rdy;
    logic [3:0]  hold;
    logic [32:0] src_q [4][$];
    beat_t       exp_q [$];
    int          n_checks;
    int          n_errors;

    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic [1:0]  s_id;
    logic [3:0]  s_ready;

    skid_rr_arbiter #(.N_PORTS(4), .DATA_WIDTH(32), .MAX_BURST(16)) dut_b16 (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .in_data_i(in_data[0]), .in_last_i(in_last[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .out_data_o(out_data[0]), .out_last_o(out_last[0]), .out_id_o(out_id[0])
    );

    skid_rr_arbiter #(.N_PORTS(4), .DATA_WIDTH(32), .MAX_BURST(4)) dut_b4 (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .in_data_i(in_data[1]), .in_last_i(in_last[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .out_data_o(out_data[1]), .out_last_o(out_last[1]), .out_id_o(out_id[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp_v, $time);
        end
    endtask

    task automatic push_src(input int p, input logic [31:0] d, input logic l);
        src_q[p].push_back({l, d});
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [31:0] d, input logic l);
        beat_t b;
        b.last = l;
        b.id   = id;
        b.data = d;
        exp_q.push_back(b);
    endtask

    // One clock: drive at negedge, sample before posedge, retire accepted beats.
    task automatic cycle();
        logic [3:0]       vld;
        logic [3:0]       lst;
        logic [3:0][31:0] dat;
        logic [3:0]       acc;
        beat_t            b;
        for (int p = 0; p < 4; p++) begin
            if (src_q[p].size() > 0 && !hold[p]) begin
                vld[p] = 1'b1;
                dat[p] = src_q[p][0][31:0];
                lst[p] = src_q[p][0][32];
            end else begin
                vld[p] = 1'b0;
                dat[p] = 32'd0;
                lst[p] = 1'b0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = (i == cur) ? vld : 4'd0;
            in_data[i]   = (i == cur) ? dat : '0;
            in_last[i]   = (i == cur) ? lst : 4'd0;
            out_ready[i] = (i == cur) ? rdy : 1'b1;
        end
        #3;
        s_valid = out_valid[cur];
        s_data  = out_data[cur];
        s_last  = out_last[cur];
        s_id    = out_id[cur];
        s_ready = in_ready[cur];
        acc     = vld & s_ready;
        check_eq("ready_onehot", 32'($countones(s_ready) <= 1), 32'd1);
        if (s_valid && rdy) begin
            check_eq("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                check_eq("beat_id", 32'(s_id), 32'(b.id));
                check_eq("beat_data", s_data, b.data);
                check_eq("beat_last", 32'(s_last), 32'(b.last));
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) begin
            if (acc[p]) begin
                void'(src_q[p].pop_front());
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        check_eq("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cur      = 0;
        rdy      = 1'b1;
        hold     = 4'd0;
        rst      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 4'd0;
            in_data[i]   = '0;
            in_last[i]   = 4'd0;
            out_ready[i] = 1'b1;
        end

        // T1: all ports valid through reset release, single-beat packets.
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 4; p++) begin
                push_src(p, 32'hA0 + 32'(p) + 32'(r * 16), 1'b1);
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 4; p++) begin
                push_exp(2'(p), 32'hA0 + 32'(p) + 32'(r * 16), 1'b1);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            cycle();
            check_eq("rst_ready", 32'(s_ready), 32'd0);
            check_eq("rst_valid", 32'(s_valid), 32'd0);
            check_eq("rst_data", s_data, 32'd0);
            check_eq("rst_id", 32'(s_id), 32'd0);
            check_eq("rst_last", 32'(s_last), 32'd0);
        end
        rst = 1'b1;
        cycle();
        check_eq("first_ready", 32'(s_ready), 32'h1);
        check_eq("first_latency", 32'(s_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            cycle();
            check_eq("tput_valid", 32'(s_valid), 32'd1);
        end
        check_eq("t1_sb_empty", 32'(exp_q.size()), 32'd0);
        cycle();
        check_eq("t1_valid_clear", 32'(s_valid), 32'd0);

        // T2: port 1 five-beat packet amid single beats on ports 0 and 2.
        push_src(0, 32'hC0, 1'b1);
        for (int k = 0; k < 5; k++) push_src(1, 32'hD000_0000 + 32'(k), k == 4);
        push_src(2, 32'hE0, 1'b1);
        push_exp(2'd0, 32'hC0, 1'b1);
        for (int k = 0; k < 5; k++) push_exp(2'd1, 32'hD000_0000 + 32'(k), k == 4);
        push_exp(2'd2, 32'hE0, 1'b1);
        drain(40);

        // T3: MAX_BURST=4, port 3 ten-beat packet split around port 0 beats.
        cur = 1;
        for (int k = 0; k < 10; k++) push_src(3, 32'h3300_0000 + 32'(k), k == 9);
        for (int k = 0; k < 4; k++) push_exp(2'd3, 32'h3300_0000 + 32'(k), 1'b0);
        push_exp(2'd0, 32'h0300_0000, 1'b1);
        for (int k = 4; k < 8; k++) push_exp(2'd3, 32'h3300_0000 + 32'(k), 1'b0);
        push_exp(2'd0, 32'h0300_0001, 1'b1);
        push_exp(2'd3, 32'h3300_0008, 1'b0);
        push_exp(2'd3, 32'h3300_0009, 1'b1);
        push_exp(2'd0, 32'h0300_0002, 1'b1);
        cycle();
        for (int k = 0; k < 3; k++) push_src(0, 32'h0300_0000 + 32'(k), 1'b1);
        drain(60);

        // T4: downstream stall for 7 cycles in the middle of port 2's packet.
        cur = 0;
        for (int k = 0; k < 8; k++) begin
            push_src(2, 32'h3000_0000 + 32'(k), k == 7);
            push_exp(2'd2, 32'h3000_0000 + 32'(k), k == 7);
        end
        repeat (3) cycle();
        rdy = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cycle();
            check_eq("stall_valid", 32'(s_valid), 32'd1);
            check_eq("stall_data", s_data, 32'h3000_0002);
            check_eq("stall_id", 32'(s_id), 32'd2);
            check_eq("stall_last", 32'(s_last), 32'd0);
            check_eq("stall_ready", 32'(s_ready), 32'd0);
        end
        rdy = 1'b1;
        drain(40);

        // T5: locked owner port 2 drops valid while port 0 waits.
        for (int k = 0; k < 6; k++) begin
            push_src(2, 32'h5200_0000 + 32'(k), k == 5);
            push_exp(2'd2, 32'h5200_0000 + 32'(k), k == 5);
        end
        push_exp(2'd0, 32'h5000_0000, 1'b1);
        cycle();
        push_src(0, 32'h5000_0000, 1'b1);
        cycle();
        hold = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_eq("lock_ready", 32'(s_ready), 32'h4);
        end
        hold = 4'd0;
        drain(40);

        // T6: asynchronous reset mid-packet, then restart from port 0.
        for (int k = 0; k < 6; k++) begin
            push_src(1, 32'hF000_0000 + 32'(k), k == 5);
            push_exp(2'd1, 32'hF000_0000 + 32'(k), k == 5);
        end
        repeat (3) cycle();
        check_eq("pre_rst_valid", 32'(out_valid[0]), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check_eq("async_valid", 32'(out_valid[0]), 32'd0);
        check_eq("async_ready", 32'(in_ready[0]), 32'd0);
        check_eq("async_id", 32'(out_id[0]), 32'd0);
        exp_q.delete();
        push_src(0, 32'h6000_0000, 1'b1);
        push_src(3, 32'h6300_0000, 1'b1);
        push_exp(2'd0, 32'h6000_0000, 1'b1);
        for (int k = 3; k < 6; k++) push_exp(2'd1, 32'hF000_0000 + 32'(k), k == 5);
        push_exp(2'd3, 32'h6300_0000, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        cycle();
        check_eq("post_rst_ready", 32'(s_ready), 32'h1);
        drain(40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
